// File: rtl/requant_packer.sv
// Requantizes signed accumulator results to 8-bit lanes and packs PACK lanes per output word.
// Optional saturation counter port o_sat_cnt is enabled by defining REQUANT_SAT_CNT_EN.
`ifndef ACC_W
`define ACC_W 24
`endif
`ifndef INT8
`define INT8 2'd0
`endif
`ifndef INT4
`define INT4 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module requant_packer #(
  parameter int unsigned ACC_W   = `ACC_W,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned PACK    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_mode,
  input  logic [SCALE_W-1:0]   i_scale,
  input  logic [SHIFT_W-1:0]   i_shift,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ACC_W-1:0]     i_psum,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [8*PACK-1:0]    o_data,
  output logic [PACK-1:0]      o_keep,
  output logic                 o_last
`ifdef REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]          o_sat_cnt
`endif
);

  localparam int unsigned PROD_W = ACC_W + SCALE_W + 1;
  localparam int unsigned RND_W  = PROD_W + 1;
  localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned WORD_W = 8 * PACK;

  logic en;
  logic accept;

  logic                     v1;
  logic signed [PROD_W-1:0] prod1;
  logic [1:0]               mode1;
  logic [SHIFT_W-1:0]       shift1;
  logic                     last1;

  logic                     v2;
  logic [7:0]               lane2;
  logic                     last2;

  logic [CNT_W-1:0]         cnt;
  logic [WORD_W-1:0]        acc_data;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [RND_W-1:0]  rnd_c;
  logic signed [RND_W-1:0]  sum_c;
  logic signed [RND_W-1:0]  shifted_c;
  logic signed [RND_W-1:0]  sat_hi_c;
  logic signed [RND_W-1:0]  sat_lo_c;
  logic                     is_int4_c;
  logic [7:0]               lane_c;
  logic [WORD_W-1:0]        word_c;
  logic [PACK-1:0]          keep_c;
  logic                     close_c;

  // Whole pipeline advances together whenever the output register can take a word.
  assign en      = !o_valid || i_ready;
  assign o_ready = en && !i_rst;
  assign accept  = i_valid && o_ready;

  assign prod_c = PROD_W'($signed(i_psum)) * PROD_W'($signed({1'b0, i_scale}));

  // Round-half-up right shift followed by mode-dependent clamp.
  always_comb begin
    rnd_c     = '0;
    if (shift1 != '0) rnd_c = RND_W'(1) << (shift1 - SHIFT_W'(1));
    sum_c     = RND_W'(prod1) + rnd_c;
    shifted_c = sum_c >>> shift1;
    is_int4_c = (mode1 == `INT4) || (mode1 == `INT4_VSQ);
    sat_hi_c  = is_int4_c ? RND_W'(7) : RND_W'(127);
    sat_lo_c  = is_int4_c ? -RND_W'(8) : -RND_W'(128);
    lane_c    = shifted_c[7:0];
    if (shifted_c > sat_hi_c)      lane_c = sat_hi_c[7:0];
    else if (shifted_c < sat_lo_c) lane_c = sat_lo_c[7:0];
  end

  always_comb begin
    word_c = acc_data;
    keep_c = '0;
    for (int i = 0; i < int'(PACK); i++) begin
      if (cnt == CNT_W'(i)) word_c[8*i +: 8] = lane2;
      keep_c[i] = (CNT_W'(i) <= cnt);
    end
    close_c = (cnt == CNT_W'(PACK - 1)) || last2;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1       <= 1'b0;
      prod1    <= '0;
      mode1    <= '0;
      shift1   <= '0;
      last1    <= 1'b0;
      v2       <= 1'b0;
      lane2    <= '0;
      last2    <= 1'b0;
      cnt      <= '0;
      acc_data <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_keep   <= '0;
      o_last   <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      if (accept) begin
        prod1  <= prod_c;
        mode1  <= i_mode;
        shift1 <= i_shift;
        last1  <= i_last;
      end
      v2 <= v1;
      if (v1) begin
        lane2 <= lane_c;
        last2 <= last1;
      end
      o_valid <= v2 && close_c;
      if (v2) begin
        if (close_c) begin
          o_data   <= word_c;
          o_keep   <= keep_c;
          o_last   <= last2;
          acc_data <= '0;
          cnt      <= '0;
        end else begin
          acc_data <= word_c;
          cnt      <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic clamp_c;
  assign clamp_c = (shifted_c > sat_hi_c) || (shifted_c < sat_lo_c);

  // Counts clamped beats as they leave the rounding stage; sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sat_cnt <= '0;
    end else if (en && v1 && clamp_c && (o_sat_cnt != 16'hFFFF)) begin
      o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_requant_packer.sv
// Scoreboard bench for requant_packer: arithmetic reference model feeds an expected-word queue,
// a negedge monitor compares every delivered word and checks stall behaviour.
module tb_requant_packer;

  localparam int ACC_W   = 24;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int PACK    = 4;
  localparam logic [1:0] M_INT8 = 2'd0, M_INT4 = 2'd1, M_VSQ = 2'd2;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic [1:0]           i_mode = '0;
  logic [SCALE_W-1:0]   i_scale = '0;
  logic [SHIFT_W-1:0]   i_shift = '0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [ACC_W-1:0]     i_psum = '0;
  logic                 i_last = 1'b0;
  logic                 o_valid;
  logic                 i_ready = 1'b1;
  logic [8*PACK-1:0]    o_data;
  logic [PACK-1:0]      o_keep;
  logic                 o_last;
`ifdef REQUANT_SAT_CNT_EN
  logic [15:0]          o_sat_cnt;
`endif

  requant_packer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_scale(i_scale), .i_shift(i_shift),
    .i_valid(i_valid), .o_ready(o_ready), .i_psum(i_psum), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last)
`ifdef REQUANT_SAT_CNT_EN
    , .o_sat_cnt(o_sat_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [8*PACK-1:0] data;
    logic [PACK-1:0]   keep;
    logic              last;
  } word_t;

  word_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8*PACK-1:0] m_word = '0;
  int                m_cnt = 0;
  int                m_sat = 0;

  bit stall_force = 1'b0;
  bit rand_ready  = 1'b0;

  function automatic logic [7:0] requant(input longint psum, input logic [1:0] mode,
                                         input longint scale, input int shift, output bit clamped);
    longint p, r, hi, lo;
    logic [63:0] rv;
    p = psum * scale;
    if (shift == 0) r = p;
    else r = (p + (longint'(1) << (shift - 1))) >>> shift;
    if (mode == M_INT4 || mode == M_VSQ) begin hi = 7; lo = -8; end
    else begin hi = 127; lo = -128; end
    clamped = (r > hi) || (r < lo);
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    rv = 64'(r);
    return rv[7:0];
  endfunction

  task automatic model_beat(input logic signed [ACC_W-1:0] psum, input logic [1:0] mode,
                            input logic [SCALE_W-1:0] scale, input logic [SHIFT_W-1:0] shift,
                            input logic last);
    bit cl;
    logic [7:0] lane;
    word_t w;
    lane = requant(longint'(psum), mode, longint'(scale), int'(shift), cl);
    if (cl) m_sat++;
    m_word[8*m_cnt +: 8] = lane;
    m_cnt++;
    if (m_cnt == PACK || last) begin
      w.data = m_word;
      w.keep = PACK'((1 << m_cnt) - 1);
      w.last = last;
      exp_q.push_back(w);
      m_word = '0;
      m_cnt  = 0;
    end
  endtask

  // Drive one beat and hold it until the DUT accepts it.
  task automatic send(input logic signed [ACC_W-1:0] psum, input logic [1:0] mode,
                      input logic [SCALE_W-1:0] scale, input logic [SHIFT_W-1:0] shift,
                      input logic last);
    bit acc;
    int n;
    n = 0;
    i_valid = 1'b1; i_psum = psum; i_mode = mode; i_scale = scale; i_shift = shift; i_last = last;
    do begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: beat psum=%0d not accepted within %0d cycles", psum, n);
    end else begin
      model_beat(psum, mode, scale, shift, last);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge i_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words still pending, required 0", exp_q.size());
    end
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  always @(posedge i_clk) begin
    #1;
    i_ready = stall_force ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: words, stall stability, and o_ready while stalled.
  bit    prev_stall = 1'b0;
  word_t prev_w;
  always @(negedge i_clk) begin
    word_t got, exp;
    got.data = o_data; got.keep = o_keep; got.last = o_last;
    if (prev_stall && !i_rst) begin
      checks++;
      if (!o_valid || got != prev_w) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b word=%h/%h/%0b, required valid=1 word=%h/%h/%0b",
                 o_valid, got.data, got.keep, got.last, prev_w.data, prev_w.keep, prev_w.last);
      end
    end
    if (o_valid && !i_ready && !i_rst) begin
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready: o_ready=%0b, required 0", o_ready);
      end
    end
    prev_stall = o_valid && !i_ready && !i_rst;
    prev_w     = got;
    if (o_valid && i_ready && !i_rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: data=%h keep=%h last=%0b, required no word",
                 o_data, o_keep, o_last);
      end else begin
        exp = exp_q.pop_front();
        if (got != exp) begin
          errors++;
          $display("FAIL word: data=%h keep=%h last=%0b, required data=%h keep=%h last=%0b",
                   got.data, got.keep, got.last, exp.data, exp.keep, exp.last);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  initial begin
    // Reset state
    @(negedge i_clk);
    check_bit("ready_in_reset", o_ready, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_bit("reset_valid", o_valid, 1'b0);
    check_bit("reset_last", o_last, 1'b0);
    checks++;
    if (o_data !== '0 || o_keep !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h keep=%h, required 0/0", o_data, o_keep);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Directed INT8 saturation word
    send(5, M_INT8, 1, 0, 0);
    send(-3, M_INT8, 1, 0, 0);
    send(200, M_INT8, 1, 0, 0);
    send(-200, M_INT8, 1, 0, 0);
    // Rounding: 15>>2 -> 4, 1.5 -> 2, -1.5 -> -1, closed by last
    send(5, M_INT8, 3, 2, 0);
    send(3, M_INT8, 1, 1, 0);
    send(-3, M_INT8, 1, 1, 1);
    // INT4_VSQ clamp
    send(9, M_VSQ, 1, 0, 0);
    send(-9, M_VSQ, 1, 0, 0);
    send(7, M_VSQ, 1, 0, 0);
    send(-8, M_VSQ, 1, 0, 0);
    // Partial word closed by last, then next beat in lane 0; last on lane PACK-1
    send(1, M_INT8, 1, 0, 0);
    send(2, M_INT8, 1, 0, 1);
    send(10, M_INT8, 1, 0, 0);
    send(11, M_INT4, 1, 0, 0);
    send(12, M_INT8, 1, 0, 0);
    send(13, 2'd3, 1, 0, 1);
    drain();

    // Continuous stream with a 10-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 40; i++) send(ACC_W'(i * 7 - 100), M_INT8, 1, 0, 0);
      end
      begin
        repeat (15) @(posedge i_clk);
        stall_force = 1'b1;
        repeat (10) @(posedge i_clk);
        stall_force = 1'b0;
      end
    join
    drain();

    // Reset mid-operation discards in-flight beats and the partial word
    send(1, M_INT8, 1, 0, 0);
    send(2, M_INT8, 1, 0, 0);
    send(3, M_INT8, 1, 0, 0);
    i_rst = 1'b1;
    m_word = '0; m_cnt = 0; m_sat = 0;
    @(negedge i_clk);
    check_bit("ready_mid_reset", o_ready, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int i = 1; i <= 4; i++) send(ACC_W'(i), M_INT8, 1, 0, 0);
    drain();

    // Randomized beats with random downstream backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic signed [ACC_W-1:0] ps;
      logic [SCALE_W-1:0] sc;
      ps = $signed(ACC_W'($urandom)) >>> $urandom_range(0, ACC_W - 1);
      sc = SCALE_W'($urandom) >> $urandom_range(0, SCALE_W);
      send(ps, 2'($urandom_range(0, 3)), sc, SHIFT_W'($urandom_range(0, 31)),
           (i == 299) || ($urandom_range(0, 5) == 0));
    end
    rand_ready = 1'b0;
    drain();

`ifdef REQUANT_SAT_CNT_EN
    checks++;
    if (o_sat_cnt != 16'(m_sat)) begin
      errors++;
      $display("FAIL sat_cnt: got %0d, required %0d", o_sat_cnt, m_sat);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
